rn_rat_ckpt: RTL and testbench
==============================

Name: rn_rat_ckpt

Overview:
Parametrised register alias table for the rename stage, successor to the single-snapshot RAT. Translates IW logical sources and destinations per cycle, with intra-group dependency bypass. Keeps a ring of speculative checkpoints for single-cycle branch-mispredict recovery and a committed RAT for full-flush recovery. Sits between decode/free-list and the rename pipeline register feeding issue.

Parameters:
CONFIG_P_ISSUE_WIDTH, 1, log2 rename group width; IW = 1<<CONFIG_P_ISSUE_WIDTH
CONFIG_P_COMMIT_WIDTH, 1, log2 commit width; CW = 1<<CONFIG_P_COMMIT_WIDTH
CONFIG_P_CKPT_NUM, 2, log2 checkpoint count; CN = 1<<CONFIG_P_CKPT_NUM
LRF_AW, 5, logical register address width
PRF_AW, 6, physical register address width (must be >= LRF_AW)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  full rollback to committed RAT
we  in  IW  per-slot rename fire (group accepted)
lrs1  in  IW*LRF_AW  source-1 logical regs
lrs2  in  IW*LRF_AW  source-2 logical regs
lrd  in  IW*LRF_AW  destination logical regs
lrd_we  in  IW  destination write enables
fl_prd  in  IW*PRF_AW  newly allocated physical regs from free list
prs1  out  IW*PRF_AW  renamed source 1 (combinational)
prs2  out  IW*PRF_AW  renamed source 2 (combinational)
pfree  out  IW*PRF_AW  previous mapping of lrd, freed at commit (combinational)
ckpt_req  in  1  take checkpoint after this cycle's group
ckpt_id  out  CONFIG_P_CKPT_NUM  id given to a checkpoint requested this cycle (tail pointer)
ckpt_full  out  1  all CN checkpoints in use
ckpt_release  in  1  oldest checkpoint's branch resolved correctly; free it
restore  in  1  mispredict: restore spec RAT from checkpoint
restore_id  in  CONFIG_P_CKPT_NUM  checkpoint to restore
cmt_fire  in  CW  commit slot valid
cmt_lrd  in  CW*LRF_AW  committed logical dest
cmt_prd  in  CW*PRF_AW  committed physical dest
cmt_prd_we  in  CW  committed dest write enable

Behaviour:
- Reset: spec RAT, committed RAT and all checkpoints map entry i -> i; head = tail = 0, count = 0; thus ckpt_id = 0, ckpt_full = 0, prsX = zero-extended lrsX.
- r0 is never renamed: a write is effective only if we[i] & lrd_we[i] & (lrd[i] != 0); lookups of r0 always return 0.
- Lookup: prsX[i] = spec RAT[lrsX[i]], overridden by fl_prd[j] of the highest slot j < i with effective write to lrsX[i]. pfree[i] is the same lookup on lrd[i]. Slot 0 uses the table only.
- Update: spec RAT written at clk edge; for duplicate lrd within a group the highest slot wins.
- Checkpoint: if ckpt_req & ~ckpt_full, ckpt[tail] <= next spec RAT (includes this group's writes); tail++ (mod CN), count++. ckpt_req while full is dropped (upstream must stall on ckpt_full).
- ckpt_release: head++, count--; ignored when count == 0. Release and accepted request in the same cycle: count unchanged, both pointers advance.
- Restore: spec RAT <= ckpt[restore_id]; tail <= restore_id; count <= (restore_id - head) mod CN (the restored and all younger checkpoints discarded). we and ckpt_req ignored that cycle; same-cycle ckpt_release is honoured (head++, count adjusted). restore_id outside the live range is illegal.
- Committed RAT: for each cmt_fire & cmt_prd_we slot with nonzero cmt_lrd, committed RAT[cmt_lrd] <= cmt_prd; highest slot wins. Always applied, even during flush/restore.
- Flush (highest priority): spec RAT <= next committed RAT (including same-cycle commits); head = tail = count = 0; restore, we, ckpt_req, ckpt_release ignored.
- Priority: flush > restore > normal rename/checkpoint.
- Reset mid-operation returns all state to reset values asynchronously.

Optional Feature:
RN_RAT_CKPT_PERF_EN: when defined, adds outputs perf_restore_cnt (32) and perf_ckpt_full_cnt (32): counts of accepted restores and of cycles with ckpt_full & ckpt_req; both reset to 0, wrap at 2^32, cleared neither by flush nor restore. When undefined, ports and logic are absent; functional behaviour is identical.

Test Plan:
Reset, lrs1[0]=5, lrs2[1]=0 -> prs1[0]=5, prs2[1]=0, ckpt_full=0, ckpt_id=0.
Group: slot0 lrd=3 fl_prd=40, slot1 lrs1=3 lrd=3 fl_prd=41 -> prs1[1]=40, pfree[0]=3, pfree[1]=40; next cycle lookup r3 -> 41.
ckpt_req with slot0 r7->50 (ckpt_id=0); next cycle r7->51; restore restore_id=0 -> following cycle r7 -> 50, ckpt_id=0, count 0.
Four accepted ckpt_req -> ckpt_full=1; fifth ckpt_req dropped, tail unchanged; ckpt_release -> ckpt_full=0; release plus ckpt_req same cycle -> ckpt_full stays as before.
Commit r2->33, then rename r2->34, then flush with we=1 slot0 r2->35 -> r2 lookup 33, count 0, ckpt_full=0.
Slot0 lrd=0 lrd_we=1 fl_prd=60 -> r0 lookup stays 0; perf counters (with RN_RAT_CKPT_PERF_EN) increment exactly once per restore/full-drop cycle.

Source files
------------

// File: rtl/rn_rat_ckpt.sv
// Register alias table with intra-group bypass, a ring of speculative checkpoints and a committed RAT.
// Define RN_RAT_CKPT_PERF_EN to add the restore / checkpoint-full performance counters.

// Per-slot lookup: table read, overridden by the youngest older slot in the group writing the same register.
module rn_rat_ckpt_lane #(
  parameter int IW     = 2,
  parameter int SLOT   = 0,
  parameter int LRF_AW = 5,
  parameter int PRF_AW = 6
) (
  input  logic [(1<<LRF_AW)-1:0][PRF_AW-1:0] rat,
  input  logic [IW-1:0]                      eff,
  input  logic [IW-1:0][LRF_AW-1:0]          lrd,
  input  logic [IW-1:0][PRF_AW-1:0]          fl_prd,
  input  logic [LRF_AW-1:0]                  lrs1,
  input  logic [LRF_AW-1:0]                  lrs2,
  output logic [PRF_AW-1:0]                  prs1,
  output logic [PRF_AW-1:0]                  prs2,
  output logic [PRF_AW-1:0]                  pfree
);
  function automatic logic [PRF_AW-1:0] xlate(
    input logic [(1<<LRF_AW)-1:0][PRF_AW-1:0] tbl,
    input logic [IW-1:0]                      wen,
    input logic [IW-1:0][LRF_AW-1:0]          wr,
    input logic [IW-1:0][PRF_AW-1:0]          wp,
    input logic [LRF_AW-1:0]                  lr
  );
    logic [PRF_AW-1:0] r;
    r = tbl[lr];
    for (int j = 0; j < IW; j++)
      if (j < SLOT && wen[j] && wr[j] == lr) r = wp[j];
    if (lr == '0) r = '0;
    return r;
  endfunction

  always_comb begin
    prs1  = xlate(rat, eff, lrd, fl_prd, lrs1);
    prs2  = xlate(rat, eff, lrd, fl_prd, lrs2);
    pfree = xlate(rat, eff, lrd, fl_prd, lrd[SLOT]);
  end
endmodule

module rn_rat_ckpt #(
  parameter int CONFIG_P_ISSUE_WIDTH  = 1,
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  parameter int CONFIG_P_CKPT_NUM     = 2,
  parameter int LRF_AW                = 5,
  parameter int PRF_AW                = 6
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 flush,
  input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                 we,
  input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0][LRF_AW-1:0]     lrs1,
  input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0][LRF_AW-1:0]     lrs2,
  input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0][LRF_AW-1:0]     lrd,
  input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                 lrd_we,
  input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0][PRF_AW-1:0]     fl_prd,
  output logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0][PRF_AW-1:0]     prs1,
  output logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0][PRF_AW-1:0]     prs2,
  output logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0][PRF_AW-1:0]     pfree,
  input  logic                                                 ckpt_req,
  output logic [CONFIG_P_CKPT_NUM-1:0]                         ckpt_id,
  output logic                                                 ckpt_full,
  input  logic                                                 ckpt_release,
  input  logic                                                 restore,
  input  logic [CONFIG_P_CKPT_NUM-1:0]                         restore_id,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]                cmt_fire,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0][LRF_AW-1:0]    cmt_lrd,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0][PRF_AW-1:0]    cmt_prd,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]                cmt_prd_we
`ifdef RN_RAT_CKPT_PERF_EN
  ,
  output logic [31:0]                                          perf_restore_cnt,
  output logic [31:0]                                          perf_ckpt_full_cnt
`endif
);
  localparam int IW  = 1 << CONFIG_P_ISSUE_WIDTH;
  localparam int CW  = 1 << CONFIG_P_COMMIT_WIDTH;
  localparam int CN  = 1 << CONFIG_P_CKPT_NUM;
  localparam int CKW = CONFIG_P_CKPT_NUM;
  localparam int NL  = 1 << LRF_AW;

  typedef logic [NL-1:0][PRF_AW-1:0] rat_t;

  rat_t           spec_rat, cmt_rat, spec_nxt, cmt_nxt;
  rat_t           ckpt [CN];
  logic [CKW-1:0] head, tail, head_rel;
  logic [CKW:0]   count;
  logic [IW-1:0]  eff;
  logic           acc, rel;

  function automatic rat_t identity_map();
    rat_t m;
    for (int i = 0; i < NL; i++) m[i] = PRF_AW'(i);
    return m;
  endfunction

  always_comb
    for (int i = 0; i < IW; i++) eff[i] = we[i] & lrd_we[i] & (lrd[i] != '0);

  for (genvar g = 0; g < IW; g++) begin : g_lane
    rn_rat_ckpt_lane #(.IW(IW), .SLOT(g), .LRF_AW(LRF_AW), .PRF_AW(PRF_AW)) u_lane (
      .rat(spec_rat), .eff(eff), .lrd(lrd), .fl_prd(fl_prd),
      .lrs1(lrs1[g]), .lrs2(lrs2[g]),
      .prs1(prs1[g]), .prs2(prs2[g]), .pfree(pfree[g])
    );
  end

  // Later slots overwrite earlier ones, so the youngest duplicate wins.
  always_comb begin
    spec_nxt = spec_rat;
    for (int i = 0; i < IW; i++)
      if (eff[i]) spec_nxt[lrd[i]] = fl_prd[i];
    cmt_nxt = cmt_rat;
    for (int i = 0; i < CW; i++)
      if (cmt_fire[i] && cmt_prd_we[i] && cmt_lrd[i] != '0) cmt_nxt[cmt_lrd[i]] = cmt_prd[i];
  end

  assign ckpt_id   = tail;
  assign ckpt_full = (count == (CKW+1)'(CN));
  assign acc       = ckpt_req & ~ckpt_full;
  assign rel       = ckpt_release & (count != '0);
  assign head_rel  = head + CKW'(rel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_rat <= identity_map();
      cmt_rat  <= identity_map();
      for (int k = 0; k < CN; k++) ckpt[k] <= identity_map();
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      cmt_rat <= cmt_nxt;
      if (flush) begin
        spec_rat <= cmt_nxt;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else if (restore) begin
        // Restored checkpoint and everything younger are discarded.
        spec_rat <= ckpt[restore_id];
        tail  <= restore_id;
        head  <= head_rel;
        count <= {1'b0, CKW'(restore_id - head_rel)};
      end else begin
        spec_rat <= spec_nxt;
        if (acc) ckpt[tail] <= spec_nxt;
        tail  <= tail + CKW'(acc);
        head  <= head_rel;
        count <= count + (CKW+1)'(acc) - (CKW+1)'(rel);
      end
    end
  end

`ifdef RN_RAT_CKPT_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_restore_cnt   <= '0;
      perf_ckpt_full_cnt <= '0;
    end else begin
      if (restore && !flush)  perf_restore_cnt   <= perf_restore_cnt + 32'd1;
      if (ckpt_full && ckpt_req) perf_ckpt_full_cnt <= perf_ckpt_full_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rn_rat_ckpt.sv
// Directed scoreboard bench for rn_rat_ckpt: stimulus queues expectations, a negedge monitor checks them.
module tb_rn_rat_ckpt;
  localparam int IW = 2, CW = 2, LRF_AW = 5, PRF_AW = 6, CKW = 2;
  localparam int S_P1_0 = 0, S_P1_1 = 1, S_P2_0 = 2, S_P2_1 = 3, S_PF_0 = 4, S_PF_1 = 5,
                 S_ID = 6, S_FULL = 7, S_PR = 8, S_PFC = 9;

  logic clk = 1'b0, rst = 1'b1, flush;
  logic [IW-1:0] we, lrd_we;
  logic [IW-1:0][LRF_AW-1:0] lrs1, lrs2, lrd;
  logic [IW-1:0][PRF_AW-1:0] fl_prd, prs1, prs2, pfree;
  logic ckpt_req, ckpt_full, ckpt_release, restore;
  logic [CKW-1:0] ckpt_id, restore_id;
  logic [CW-1:0] cmt_fire, cmt_prd_we;
  logic [CW-1:0][LRF_AW-1:0] cmt_lrd;
  logic [CW-1:0][PRF_AW-1:0] cmt_prd;
`ifdef RN_RAT_CKPT_PERF_EN
  logic [31:0] perf_restore_cnt, perf_ckpt_full_cnt;
`endif

  rn_rat_ckpt dut (
    .clk(clk), .rst(rst), .flush(flush), .we(we), .lrs1(lrs1), .lrs2(lrs2), .lrd(lrd),
    .lrd_we(lrd_we), .fl_prd(fl_prd), .prs1(prs1), .prs2(prs2), .pfree(pfree),
    .ckpt_req(ckpt_req), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full), .ckpt_release(ckpt_release),
    .restore(restore), .restore_id(restore_id), .cmt_fire(cmt_fire), .cmt_lrd(cmt_lrd),
    .cmt_prd(cmt_prd), .cmt_prd_we(cmt_prd_we)
`ifdef RN_RAT_CKPT_PERF_EN
    , .perf_restore_cnt(perf_restore_cnt), .perf_ckpt_full_cnt(perf_ckpt_full_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { string name; int sel; int val; } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;

  function automatic int actual(input int sel);
    case (sel)
      S_P1_0: return int'(prs1[0]);
      S_P1_1: return int'(prs1[1]);
      S_P2_0: return int'(prs2[0]);
      S_P2_1: return int'(prs2[1]);
      S_PF_0: return int'(pfree[0]);
      S_PF_1: return int'(pfree[1]);
      S_ID:   return int'(ckpt_id);
      S_FULL: return int'(ckpt_full);
`ifdef RN_RAT_CKPT_PERF_EN
      S_PR:   return int'(perf_restore_cnt);
      S_PFC:  return int'(perf_ckpt_full_cnt);
`endif
      default: return -1;
    endcase
  endfunction

  // Monitor: drains every queued expectation against the settled outputs.
  initial forever begin
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e;
      int a;
      e = exp_q.pop_front();
      a = actual(e.sel);
      checks++;
      if (a != e.val) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.name, a, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic expect_v(input string n, input int sel, input int v);
    exp_t e;
    e.name = n; e.sel = sel; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic clr();
    flush = 0; we = '0; lrd_we = '0; lrs1 = '0; lrs2 = '0; lrd = '0; fl_prd = '0;
    ckpt_req = 0; ckpt_release = 0; restore = 0; restore_id = '0;
    cmt_fire = '0; cmt_lrd = '0; cmt_prd = '0; cmt_prd_we = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic wr(input int s, input int rd, input int prd);
    we[s] = 1'b1; lrd_we[s] = 1'b1; lrd[s] = LRF_AW'(rd); fl_prd[s] = PRF_AW'(prd);
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    step(); lrs1[0] = 5; lrs2[1] = 0;
    expect_v("rst_prs1_0", S_P1_0, 5); expect_v("rst_prs2_1", S_P2_1, 0);
    expect_v("rst_full", S_FULL, 0);   expect_v("rst_id", S_ID, 0);

    step(); wr(0, 3, 40); wr(1, 3, 41); lrs1[0] = 3; lrs1[1] = 3;
    expect_v("slot0_nobypass", S_P1_0, 3); expect_v("bypass_prs1_1", S_P1_1, 40);
    expect_v("pfree0", S_PF_0, 3);         expect_v("pfree1_bypass", S_PF_1, 40);
    step(); lrs1[0] = 3;
    expect_v("dup_lrd_high_wins", S_P1_0, 41);

    step(); wr(0, 7, 50); ckpt_req = 1; lrs1[1] = 7;
    expect_v("ckpt_id_first", S_ID, 0); expect_v("bypass_r7", S_P1_1, 50);
    step(); wr(0, 7, 51); lrs1[0] = 7;
    expect_v("r7_after_ckpt", S_P1_0, 50); expect_v("ckpt_id_after", S_ID, 1);
    step(); lrs1[0] = 7; restore = 1; restore_id = 0; wr(0, 7, 52);
    expect_v("r7_pre_restore", S_P1_0, 51);
    step(); lrs1[0] = 7;
    expect_v("r7_restored", S_P1_0, 50); expect_v("restore_id_tail", S_ID, 0);
    expect_v("restore_full", S_FULL, 0);

    for (int k = 0; k < 4; k++) begin
      step(); ckpt_req = 1;
      expect_v("fill_id", S_ID, k); expect_v("fill_full", S_FULL, 0);
    end
    step(); ckpt_req = 1;
    expect_v("full_after4", S_FULL, 1); expect_v("full_id", S_ID, 0);
    step();
    expect_v("drop_full", S_FULL, 1); expect_v("drop_tail", S_ID, 0);
    step(); ckpt_release = 1;
    expect_v("rel_pre_full", S_FULL, 1);
    step(); ckpt_release = 1; ckpt_req = 1;
    expect_v("rel_full", S_FULL, 0); expect_v("rel_id", S_ID, 0);
    step(); ckpt_req = 1;
    expect_v("relreq_full", S_FULL, 0); expect_v("relreq_id", S_ID, 1);
    step(); restore = 1; restore_id = 3; ckpt_release = 1;
    expect_v("refull", S_FULL, 1); expect_v("refull_id", S_ID, 2);
    step();
    expect_v("rstr_rel_full", S_FULL, 0); expect_v("rstr_rel_id", S_ID, 3);
    for (int k = 0; k < 4; k++) begin
      step(); ckpt_req = 1;
      expect_v("refill_full", S_FULL, 0); expect_v("refill_id", S_ID, (3 + k) % 4);
    end

    step(); cmt_fire = 2'b11; cmt_prd_we = 2'b11; cmt_lrd[0] = 2; cmt_lrd[1] = 2;
    cmt_prd[0] = 30; cmt_prd[1] = 33;
    expect_v("refill_done_full", S_FULL, 1); expect_v("refill_done_id", S_ID, 3);
    step(); wr(0, 2, 34); lrs1[0] = 2;
    expect_v("cmt_not_spec", S_P1_0, 2);
    step(); lrs1[0] = 2; flush = 1; wr(0, 2, 35);
    cmt_fire[0] = 1; cmt_prd_we[0] = 1; cmt_lrd[0] = 4; cmt_prd[0] = 44;
    expect_v("pre_flush_r2", S_P1_0, 34);
    step(); lrs1[0] = 2; lrs2[0] = 4; lrs1[1] = 3;
    expect_v("flush_r2", S_P1_0, 33); expect_v("flush_same_cmt_r4", S_P2_0, 44);
    expect_v("flush_r3", S_P1_1, 3);  expect_v("flush_full", S_FULL, 0);
    expect_v("flush_id", S_ID, 0);

    step(); wr(0, 0, 60); wr(1, 0, 61); lrs1[1] = 0; lrs2[1] = 0;
    expect_v("r0_nobypass1", S_P1_1, 0); expect_v("r0_nobypass2", S_P2_1, 0);
    expect_v("r0_pfree0", S_PF_0, 0);    expect_v("r0_pfree1", S_PF_1, 0);
    step(); lrs1[0] = 0;
    expect_v("r0_table", S_P1_0, 0);
`ifdef RN_RAT_CKPT_PERF_EN
    expect_v("perf_restore", S_PR, 2); expect_v("perf_full", S_PFC, 1);
`endif

    step(); rst = 1; lrs1[0] = 2; lrs1[1] = 4;
    expect_v("async_rst_r2", S_P1_0, 2); expect_v("async_rst_r4", S_P1_1, 4);
    expect_v("async_rst_full", S_FULL, 0);
    step(); rst = 0;

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
